// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-zone alarm controller.
// State codes double as the selsw selector value.
package alarm_pkg;

  localparam int SELSW_W = 3;

  typedef enum logic [SELSW_W-1:0] {
    S_DISARMED = 3'b000,
    S_ARMING   = 3'b001,
    S_ARMED    = 3'b010,
    S_ENTRY    = 3'b011,
    S_ALARM    = 3'b100,
    S_SILENCED = 3'b101
  } state_t;

  // Bits needed to hold the largest of the three delays.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alarm_multizone_debounce.sv
// Per-zone debounce: saturating run counter of qualified high cycles.
// trip holds while saturated; trip_rise marks its first cycle only.
module zone_debounce #(
  parameter int CONFIRM = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic en,
  output logic trip,
  output logic trip_rise
);

  localparam int CW = $clog2(CONFIRM + 1);
  localparam logic [CW-1:0] SAT = CW'(CONFIRM);

  logic [CW-1:0] r_cnt;
  logic          r_trip_d;

  // Count qualified highs, clear on any low or bypassed cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_trip_d <= 1'b0;
    end else begin
      if (in && en) begin
        if (r_cnt != SAT) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      r_trip_d <= trip;
    end
  end

  assign trip      = (r_cnt == SAT);
  assign trip_rise = trip & ~r_trip_d;

endmodule

// File: rtl/alarm_multizone.sv
// Multi-zone alarm: debounced zones, arm/entry/exit timing,
// timed siren with silenced re-trigger on fresh zones.
module alarm_multizone
  import alarm_pkg::*;
#(
  parameter int ZONES        = 4,
  parameter int CONFIRM      = 3,
  parameter int EXIT_DELAY   = 8,
  parameter int ENTRY_DELAY  = 6,
  parameter int SIREN_CYCLES = 10,
  parameter logic [ZONES-1:0] DELAY_MASK = ZONES'(1),
  parameter int TW           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               disarm,
  input  logic [ZONES-1:0]   x,
  input  logic [ZONES-1:0]   zone_en,
  output logic [SELSW_W-1:0] selsw,
  output logic               alarm,
  output logic               armed,
  output logic [ZONES-1:0]   latched
);

  localparam logic [TW-1:0] EXIT_LD  = TW'(EXIT_DELAY - 1);
  localparam logic [TW-1:0] ENTRY_LD = TW'(ENTRY_DELAY - 1);
  localparam logic [TW-1:0] SIREN_LD = TW'(SIREN_CYCLES - 1);

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [ZONES-1:0] r_latched;
  logic             r_alarm;

  logic [ZONES-1:0] w_trip;
  logic [ZONES-1:0] w_rise;
  logic [ZONES-1:0] w_ev;
  logic [ZONES-1:0] w_inst;
  logic [ZONES-1:0] w_new;
  logic             w_tz;
  logic             w_unused_trip;

  for (genvar g = 0; g < ZONES; g++) begin : g_zone
    zone_debounce #(.CONFIRM(CONFIRM)) u_db (
      .clk       (clk),
      .reset     (reset),
      .in        (x[g]),
      .en        (zone_en[g]),
      .trip      (w_trip[g]),
      .trip_rise (w_rise[g])
    );
  end

  assign w_unused_trip = ^w_trip;
  assign w_ev   = w_rise & zone_en;
  assign w_inst = w_ev & ~DELAY_MASK;
  assign w_new  = w_ev & ~r_latched;
  assign w_tz   = (r_timer == '0);

  // Alarm FSM with shared countdown, latched zones and siren register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_DISARMED;
      r_timer   <= '0;
      r_latched <= '0;
      r_alarm   <= 1'b0;
    end else begin
      r_alarm <= 1'b0;
      if (disarm) begin
        r_state   <= S_DISARMED;
        r_timer   <= '0;
        r_latched <= '0;
      end else begin
        case (r_state)
          S_DISARMED: begin
            if (arm) begin
              r_state <= S_ARMING;
              r_timer <= EXIT_LD;
            end
          end
          S_ARMING: begin
            if (w_tz) r_state <= S_ARMED;
            else      r_timer <= r_timer - 1'b1;
          end
          S_ARMED: begin
            if (|w_ev) begin
              r_latched <= r_latched | w_ev;
              if (|w_inst) begin
                r_state <= S_ALARM;
                r_timer <= SIREN_LD;
                r_alarm <= 1'b1;
              end else begin
                r_state <= S_ENTRY;
                r_timer <= ENTRY_LD;
              end
            end
          end
          S_ENTRY: begin
            r_latched <= r_latched | w_ev;
            if ((|w_inst) || w_tz) begin
              r_state <= S_ALARM;
              r_timer <= SIREN_LD;
              r_alarm <= 1'b1;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          S_ALARM: begin
            r_latched <= r_latched | w_ev;
            if (w_tz) begin
              r_state <= S_SILENCED;
            end else begin
              r_timer <= r_timer - 1'b1;
              r_alarm <= 1'b1;
            end
          end
          S_SILENCED: begin
            if (|w_new) begin
              r_state   <= S_ALARM;
              r_timer   <= SIREN_LD;
              r_latched <= r_latched | w_new;
              r_alarm   <= 1'b1;
            end
          end
          default: begin
            r_state   <= S_DISARMED;
            r_timer   <= '0;
            r_latched <= '0;
          end
        endcase
      end
    end
  end

  assign selsw   = r_state;
  assign alarm   = r_alarm;
  assign latched = r_latched;
  assign armed   = (r_state == S_ARMED) || (r_state == S_ENTRY) ||
                   (r_state == S_ALARM) || (r_state == S_SILENCED);

endmodule

// File: tb/tb_alarm_multizone.sv
// Directed bench for alarm_multizone at default parameters.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_alarm_multizone;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm;
  logic       disarm;
  logic [3:0] x;
  logic [3:0] zone_en;
  logic [2:0] selsw;
  logic       alarm;
  logic       armed;
  logic [3:0] latched;

  int checks = 0;
  int failures = 0;

  alarm_multizone dut (
    .clk     (clk),
    .reset   (reset),
    .arm     (arm),
    .disarm  (disarm),
    .x       (x),
    .zone_en (zone_en),
    .selsw   (selsw),
    .alarm   (alarm),
    .armed   (armed),
    .latched (latched)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_armed();
    x = 4'b0000;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick(8);
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] v, input int n);
    x = v;
    tick(n);
    x = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    arm = 1'b0;
    disarm = 1'b0;
    x = 4'b0000;
    zone_en = 4'b1111;
    #2;
    checks++;
    if (selsw !== 3'b000 || alarm !== 1'b0 ||
        armed !== 1'b0 || latched !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: selsw=%b alarm=%b armed=%b latched=%b want 000 0 0 0000",
               selsw, alarm, armed, latched);
    end
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (selsw !== 3'b000 || alarm !== 1'b0 || latched !== 4'b0000) begin
        failures++;
        $display("FAIL idle_%0d: selsw=%b alarm=%b latched=%b want 000 0 0000",
                 i, selsw, alarm, latched);
      end
    end
  endtask

  task automatic test_disarmed_ignore();
    logic [3:0] pat [4];
    pat[0] = 4'b1111;
    pat[1] = 4'b0101;
    pat[2] = 4'b1010;
    pat[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      x = pat[i];
      tick(5);
      checks++;
      if (selsw !== 3'b000 || latched !== 4'b0000 || alarm !== 1'b0) begin
        failures++;
        $display("FAIL disarmed_ignore_%0d: selsw=%b latched=%b alarm=%b want 000 0000 0",
                 i, selsw, latched, alarm);
      end
    end
    x = 4'b0000;
    tick(2);
  endtask

  task automatic test_arm_exit();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if (selsw !== 3'b001 || armed !== 1'b0) begin
      failures++;
      $display("FAIL arming_enter: selsw=%b armed=%b want 001 0", selsw, armed);
    end
    tick(7);
    checks++;
    if (selsw !== 3'b001) begin
      failures++;
      $display("FAIL arming_hold: selsw=%b want 001", selsw);
    end
    tick();
    checks++;
    if (selsw !== 3'b010 || armed !== 1'b1) begin
      failures++;
      $display("FAIL armed_enter: selsw=%b armed=%b want 010 1", selsw, armed);
    end
    do_disarm();
    checks++;
    if (selsw !== 3'b000 || armed !== 1'b0) begin
      failures++;
      $display("FAIL armed_disarm: selsw=%b armed=%b want 000 0", selsw, armed);
    end
  endtask

  task automatic test_disarm_arming();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick(3);
    checks++;
    if (selsw !== 3'b001) begin
      failures++;
      $display("FAIL arming_mid: selsw=%b want 001", selsw);
    end
    do_disarm();
    checks++;
    if (selsw !== 3'b000 || armed !== 1'b0) begin
      failures++;
      $display("FAIL arming_disarm: selsw=%b armed=%b want 000 0", selsw, armed);
    end
    arm = 1'b1;
    disarm = 1'b1;
    tick();
    arm = 1'b0;
    disarm = 1'b0;
    checks++;
    if (selsw !== 3'b000) begin
      failures++;
      $display("FAIL arm_disarm_same: selsw=%b want 000", selsw);
    end
  endtask

  task automatic test_instant_and_silenced();
    go_armed();
    pulse(4'b0100, 3);
    checks++;
    if (selsw !== 3'b010) begin
      failures++;
      $display("FAIL instant_pre: selsw=%b want 010", selsw);
    end
    tick();
    checks++;
    if (selsw !== 3'b100 || alarm !== 1'b1 || latched !== 4'b0100) begin
      failures++;
      $display("FAIL instant_alarm: selsw=%b alarm=%b latched=%b want 100 1 0100",
               selsw, alarm, latched);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (alarm !== 1'b1) begin
        failures++;
        $display("FAIL siren1_%0d: alarm=%b want 1", i, alarm);
      end
    end
    tick();
    checks++;
    if (selsw !== 3'b101 || alarm !== 1'b0 || latched !== 4'b0100) begin
      failures++;
      $display("FAIL silenced: selsw=%b alarm=%b latched=%b want 101 0 0100",
               selsw, alarm, latched);
    end
    pulse(4'b0100, 3);
    tick(2);
    checks++;
    if (selsw !== 3'b101 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL silenced_same_zone: selsw=%b alarm=%b want 101 0", selsw, alarm);
    end
    pulse(4'b0010, 3);
    tick();
    checks++;
    if (selsw !== 3'b100 || alarm !== 1'b1 || latched !== 4'b0110) begin
      failures++;
      $display("FAIL retrigger: selsw=%b alarm=%b latched=%b want 100 1 0110",
               selsw, alarm, latched);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (alarm !== 1'b1) begin
        failures++;
        $display("FAIL siren2_%0d: alarm=%b want 1", i, alarm);
      end
    end
    tick();
    checks++;
    if (selsw !== 3'b101 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL resilenced: selsw=%b alarm=%b want 101 0", selsw, alarm);
    end
    do_disarm();
    checks++;
    if (selsw !== 3'b000 || latched !== 4'b0000 || armed !== 1'b0) begin
      failures++;
      $display("FAIL silenced_disarm: selsw=%b latched=%b armed=%b want 000 0000 0",
               selsw, latched, armed);
    end
  endtask

  task automatic test_entry();
    go_armed();
    pulse(4'b0001, 3);
    tick();
    checks++;
    if (selsw !== 3'b011 || armed !== 1'b1 ||
        alarm !== 1'b0 || latched !== 4'b0001) begin
      failures++;
      $display("FAIL entry_enter: selsw=%b armed=%b alarm=%b latched=%b want 011 1 0 0001",
               selsw, armed, alarm, latched);
    end
    tick(5);
    checks++;
    if (selsw !== 3'b011) begin
      failures++;
      $display("FAIL entry_hold: selsw=%b want 011", selsw);
    end
    tick();
    checks++;
    if (selsw !== 3'b100 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL entry_expire: selsw=%b alarm=%b want 100 1", selsw, alarm);
    end
    do_disarm();
    go_armed();
    pulse(4'b0001, 3);
    tick(4);
    checks++;
    if (selsw !== 3'b011) begin
      failures++;
      $display("FAIL entry2_mid: selsw=%b want 011", selsw);
    end
    do_disarm();
    checks++;
    if (selsw !== 3'b000 || latched !== 4'b0000 || armed !== 1'b0) begin
      failures++;
      $display("FAIL entry_disarm: selsw=%b latched=%b armed=%b want 000 0000 0",
               selsw, latched, armed);
    end
  endtask

  task automatic test_simultaneous();
    go_armed();
    pulse(4'b0101, 3);
    tick();
    checks++;
    if (selsw !== 3'b100 || latched !== 4'b0101) begin
      failures++;
      $display("FAIL simul_trip: selsw=%b latched=%b want 100 0101", selsw, latched);
    end
    do_disarm();
  endtask

  task automatic test_glitch_bypass();
    go_armed();
    pulse(4'b1000, 2);
    tick(4);
    checks++;
    if (selsw !== 3'b010 || latched !== 4'b0000) begin
      failures++;
      $display("FAIL glitch: selsw=%b latched=%b want 010 0000", selsw, latched);
    end
    zone_en = 4'b0111;
    x = 4'b1000;
    tick(10);
    x = 4'b0000;
    tick(2);
    checks++;
    if (selsw !== 3'b010 || latched !== 4'b0000) begin
      failures++;
      $display("FAIL bypass: selsw=%b latched=%b want 010 0000", selsw, latched);
    end
    zone_en = 4'b1111;
    do_disarm();
  endtask

  task automatic test_async_reset();
    go_armed();
    pulse(4'b0100, 3);
    tick(3);
    checks++;
    if (selsw !== 3'b100 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_alarm: selsw=%b alarm=%b want 100 1", selsw, alarm);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (selsw !== 3'b000 || alarm !== 1'b0 ||
        armed !== 1'b0 || latched !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset: selsw=%b alarm=%b armed=%b latched=%b want 000 0 0 0000",
               selsw, alarm, armed, latched);
    end
    tick();
    reset = 1'b1;
    tick(2);
    checks++;
    if (selsw !== 3'b000 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: selsw=%b alarm=%b want 000 0", selsw, alarm);
    end
  endtask

  initial begin
    test_reset();
    test_disarmed_ignore();
    test_arm_exit();
    test_disarm_arming();
    test_instant_and_silenced();
    test_entry();
    test_simultaneous();
    test_glitch_bypass();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_multizone.md
Name: alarm_multizone

Overview:
- Multi-zone intrusion alarm controller; the parametrised successor to the single-input alarmSystem FSM.
- Debounces N sensor zones and applies per-zone masking and entry/exit delays.
- Runs an arm/disarm state machine with a timed siren and a silenced re-trigger mode.
- Drives the 3-bit state code selsw to the board switch/LED selector, plus siren and latched-zone indicators.

Parameters:
- ZONES, 4, number of sensor inputs (1..8).
- CONFIRM, 3, consecutive high cycles before a zone trips (>=1).
- EXIT_DELAY, 8, cycles spent in ARMING before ARMED.
- ENTRY_DELAY, 6, grace cycles for delayed zones before ALARM.
- SIREN_CYCLES, 10, cycles the siren stays on per alarm event.
- DELAY_MASK, 4'b0001, per-zone bit: 1 = delayed (entry) zone, 0 = instant zone.
- TW, 8, timer width; must hold max(EXIT_DELAY, ENTRY_DELAY, SIREN_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  arm request, level-sampled.
- disarm  in  1  disarm request, level-sampled; priority over arm.
- x  in  ZONES  raw zone sensor inputs, synchronous to clk.
- zone_en  in  ZONES  1 = zone monitored, 0 = bypassed.
- selsw  out  3  state code.
- alarm  out  1  siren drive.
- armed  out  1  high in ARMED, ENTRY, ALARM, SILENCED.
- latched  out  ZONES  zones that caused the current alarm event.

Behaviour:
- Reset (reset=0, asynchronous): state=DISARMED, selsw=3'b000, alarm=0, armed=0, latched=0, timer=0, all debounce counters=0.
- Debounce, per zone i:
  - Counter increments while x[i]&zone_en[i]; it clears on any low cycle and saturates at CONFIRM.
  - trip[i] is high while the counter equals CONFIRM, so a trip appears CONFIRM edges after x rises.
  - A sensor held high produces one trip edge only. A new event requires x[i] to drop and re-qualify.
- State codes for selsw: DISARMED=000, ARMING=001, ARMED=010, ENTRY=011, ALARM=100, SILENCED=101. Codes 110/111 are unreachable and recover to DISARMED on the next edge.
- Transitions (registered, evaluated each rising edge; disarm checked first in every state):
  - DISARMED: arm -> ARMING, timer=EXIT_DELAY-1. Trips ignored.
  - ARMING: timer decrements. disarm -> DISARMED. When timer==0 -> ARMED. Trips ignored.
  - ARMED: a rising trip on any enabled zone sets its latched bit.
    - Any tripping zone with DELAY_MASK=0 -> ALARM, timer=SIREN_CYCLES-1.
    - Otherwise -> ENTRY, timer=ENTRY_DELAY-1.
  - ENTRY: timer decrements. disarm -> DISARMED. An instant-zone trip -> ALARM immediately. When timer==0 -> ALARM. Further trips keep OR-ing into latched.
  - ALARM: alarm=1. timer decrements. disarm -> DISARMED. When timer==0 -> SILENCED. New trips OR into latched.
  - SILENCED: alarm=0. A rising trip on a zone not already latched -> ALARM, timer reloaded to SIREN_CYCLES-1, bit latched. Trips on already-latched zones are ignored. disarm -> DISARMED.
- Entering DISARMED from any state clears latched and timer on the same edge.
- Simultaneous events:
  - arm and disarm together: disarm wins.
  - In ARMED, instant and delayed trips on the same edge: ALARM wins, and both bits are latched.
- Outputs:
  - alarm is registered, high exactly SIREN_CYCLES cycles per event.
  - armed and selsw are decoded from the state register, so changes are visible one edge after the cause.
- Reset asserted mid-operation returns to DISARMED immediately, with no waiting for a clock edge.
- Clearing zone_en[i] clears that zone's counter the next cycle. Bits already latched are not cleared.

Decomposition:
- Package alarm_pkg holds:
  - the state code localparams/enum (3 bits);
  - the SELSW_W=3 constant;
  - a function computing timer width from the delay parameters.
- Sub-module zone_debounce, instantiated ZONES times via generate:
  - ports clk, reset, in, en, trip, trip_rise;
  - parameter CONFIRM.
- The top level contains the FSM, shared timer, latched register and output decode.

Test Plan (default parameters):
- Reset then idle with x=0 -> selsw=000, alarm=0, latched=0 for 20 cycles; toggling x while DISARMED causes no state change.
- arm=1 for 1 cycle -> selsw=001 next edge, 010 after 8 more edges; disarm at arm+4 -> selsw=000, armed=0.
- ARMED, x[2]=1 for 3 cycles -> selsw=100 the edge after trip, alarm=1 for exactly 10 cycles, latched=4'b0100, then selsw=101, alarm=0.
- ARMED, x[0]=1 (delayed zone) -> selsw=011. No disarm -> ALARM after 6 cycles. A disarm within the 6 cycles -> 000, latched=0.
- SILENCED with latched=0100:
  - x[2] re-pulse -> remains 101.
  - x[1] pulse of 3 cycles -> 100, latched=0110, alarm=1 for 10 cycles.
- Glitch and reset checks:
  - 2-cycle x[3] pulse in ARMED -> no trip, stays 010.
  - zone_en[3]=0 with x[3] high 10 cycles -> stays 010.
  - reset low mid-ALARM -> alarm=0, selsw=000 asynchronously.
